// File: rtl/sqr_odd_sum.sv
// Iterative squarer: out = in*in, formed by summing the first n odd numbers.
// Define SQR_STEP_MERGE_EN to fold the odd-addend update into ACC (5-state FSM, 2n+3 edges).
module sqr_odd_sum #(
  parameter int ROOT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [ROOT_W-1:0]     in,
  output logic                  over,
  output logic                  busy,
  output logic [2*ROOT_W-1:0]   out
);

  localparam int ACC_W = 2 * ROOT_W;
  localparam int K_W   = ROOT_W + 2;

`ifdef SQR_STEP_MERGE_EN
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    INIT  = 5'b00010,
    CHECK = 5'b00100,
    ACC   = 5'b01000,
    DONE  = 5'b10000
  } state_t;
`else
  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    INIT  = 6'b000010,
    CHECK = 6'b000100,
    ACC   = 6'b001000,
    STEP  = 6'b010000,
    DONE  = 6'b100000
  } state_t;
`endif

  state_t state, state_nx;

  logic [ROOT_W-1:0] n_r;
  logic [ROOT_W-1:0] cnt;
  logic [K_W-1:0]    k;
  logic [ACC_W-1:0]  acc;

  // The sum never exceeds (2^ROOT_W-1)^2, so no carry out of ACC_W is possible.
  function automatic logic [ACC_W-1:0] odd_add(input logic [ACC_W-1:0] a,
                                               input logic [K_W-1:0]   odd);
    return a + ACC_W'(odd);
  endfunction

  function automatic logic [K_W-1:0] next_odd(input logic [K_W-1:0] odd);
    return odd + K_W'(2);
  endfunction

  function automatic logic [ROOT_W-1:0] cnt_inc(input logic [ROOT_W-1:0] c);
    return c + ROOT_W'(1);
  endfunction

  function automatic logic is_busy(input state_t s);
    return (s == INIT) || (s == CHECK) || (s == ACC)
`ifndef SQR_STEP_MERGE_EN
           || (s == STEP)
`endif
           ;
  endfunction

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = go ? INIT : IDLE;
      INIT:    state_nx = CHECK;
      CHECK:   state_nx = (cnt == n_r) ? DONE : ACC;
`ifdef SQR_STEP_MERGE_EN
      ACC:     state_nx = CHECK;
`else
      ACC:     state_nx = STEP;
      STEP:    state_nx = CHECK;
`endif
      DONE:    state_nx = go ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Flags decode the next state so they switch together with state entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      over  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      over  <= (state_nx == DONE);
      busy  <= is_busy(state_nx);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_r <= '0;
      cnt <= '0;
      k   <= K_W'(1);
      acc <= '0;
    end else begin
      unique case (state)
        INIT: begin
          n_r <= in;
          acc <= '0;
          k   <= K_W'(1);
          cnt <= '0;
        end
        ACC: begin
          acc <= odd_add(acc, k);
          cnt <= cnt_inc(cnt);
`ifdef SQR_STEP_MERGE_EN
          k   <= next_odd(k);
`endif
        end
`ifndef SQR_STEP_MERGE_EN
        STEP: k <= next_odd(k);
`endif
        default: ;
      endcase
    end
  end

  assign out = acc;

endmodule

// File: tb/tb_sqr_odd_sum.sv
// Directed self-checking bench for sqr_odd_sum; latency expectations follow SQR_STEP_MERGE_EN.
module tb_sqr_odd_sum;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic [3:0] in = 4'd0;
  logic       over;
  logic       busy;
  logic [7:0] out;

  int tests = 0;
  int fails = 0;
  int edges;

  sqr_odd_sum #(.ROOT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .in    (in),
    .over  (over),
    .busy  (busy),
    .out   (out)
  );

  always #5 clk = ~clk;

  // Edges counted from the edge that samples go (counted as 1) to the edge that raises over.
  function automatic int lat(input int n);
`ifdef SQR_STEP_MERGE_EN
    return 2 * n + 3;
`else
    return 3 * n + 3;
`endif
  endfunction

  // Behavioural odd-subtraction square root, standing in for the companion sqrt engine.
  function automatic int isqrt_odd(input int v);
    int r = 0;
    int odd = 1;
    while (v >= odd) begin
      v = v - odd;
      odd = odd + 2;
      r++;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_over(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (over === 1'b1) break;
    end
  endtask

  // Starts a run from IDLE; go stays high so the FSM parks in DONE.
  task automatic run(input string tag, input int n, input int exp_sq, input int exp_edges);
    @(negedge clk);
    in = 4'(n);
    go = 1'b1;
    edges = 0;
    wait_over(200);
    chk({tag, "_over"}, 32'(over), 32'd1);
    chk({tag, "_lat"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_out"}, 32'(out), 32'(exp_sq));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic drop_go();
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_over", 32'(over), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run("n8", 8, 64, lat(8));
    drop_go();
    chk("idle_over", 32'(over), 32'd0);
    chk("idle_keep", 32'(out), 32'd64);

    run("n0", 0, 0, lat(0));
    drop_go();
    run("n15", 15, 225, lat(15));
    drop_go();

    // Held go parks in DONE, then a restart after one low cycle
    run("n3", 3, 9, lat(3));
    repeat (3) @(posedge clk);
    #1;
    chk("hold_over", 32'(over), 32'd1);
    chk("hold_busy", 32'(busy), 32'd0);
    chk("hold_out", 32'(out), 32'd9);
    drop_go();
    chk("hold_idle", 32'(over), 32'd0);
    run("n5", 5, 25, lat(5));
    drop_go();

    // Operand change and go pulse while busy are ignored
    @(negedge clk);
    in = 4'd12;
    go = 1'b1;
    edges = 0;
    repeat (4) begin
      @(posedge clk);
      edges++;
    end
    #1;
    chk("n12_busy", 32'(busy), 32'd1);
    @(negedge clk);
    in = 4'd2;
    go = 1'b0;
    @(posedge clk);
    edges++;
    @(negedge clk);
    go = 1'b1;
    wait_over(200);
    chk("n12_over", 32'(over), 32'd1);
    chk("n12_lat", 32'(edges), 32'(lat(12)));
    chk("n12_out", 32'(out), 32'd144);
    drop_go();

    // Asynchronous reset between edges mid-run
    @(negedge clk);
    in = 4'd10;
    go = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_over", 32'(over), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out", 32'(out), 32'd0);
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run("n7", 7, 49, lat(7));
    drop_go();

    // Sweep with square scoreboard and sqrt loopback
    for (int n = 0; n < 16; n++) begin
      run($sformatf("sw%0d", n), n, n * n, lat(n));
      chk($sformatf("loop%0d", n), 32'(isqrt_odd(int'(out))), 32'(n));
      drop_go();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sqr_odd_sum.md
Name: sqr_odd_sum

Overview:
- Iterative integer squarer: out = in*in, computed by accumulating successive odd numbers (1+3+5+...).
- Inverse of the team's odd-subtraction square-root engine. Uses the same go/over handshake and register-datapath-plus-one-hot-controller structure.
- Sits alongside the sqrt engine. A bench can feed the sqrt output into this block and compare the result back against the switch input.

Parameters:
- ROOT_W, 4, width of the root operand; result width is 2*ROOT_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); the block leaves reset on the first rising clk after release.
- go  input  1  start request, level-sensitive, sampled only in IDLE and DONE.
- in  input  ROOT_W  root operand n, latched in INIT.
- over  output  1  registered done flag; 1 exactly while in DONE.
- busy  output  1  registered; 1 in INIT, CHECK, ACC, STEP.
- out  output  2*ROOT_W  accumulator register; equals n*n whenever over=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, over=0, busy=0, out=0.
  - Internal regs n_r=0, k=1, cnt=0.
  - Applies mid-operation with no completion.
- Internal registers:
  - n_r: ROOT_W bits.
  - cnt: ROOT_W bits.
  - k: ROOT_W+2 bits, the odd addend.
  - acc: 2*ROOT_W bits, driven on out.
- Datapath arithmetic is unsigned and never overflows: max acc = (2^ROOT_W-1)^2, max k = 2*(2^ROOT_W-1)+1.
- FSM is one-hot, 6 states:
  - IDLE: go=1 -> INIT; else stay. acc holds its previous value.
  - INIT: n_r<=in, acc<=0, k<=1, cnt<=0 -> CHECK.
  - CHECK: cnt==n_r -> DONE; else -> ACC.
  - ACC: acc<=acc+k, cnt<=cnt+1 -> STEP.
  - STEP: k<=k+2 -> CHECK.
  - DONE: over=1, acc frozen. go=0 -> IDLE; go=1 -> stay in DONE (no auto-restart).
- Latency: go sampled high at edge T in IDLE -> over=1 after edge T+3n+3. Examples: n=0 -> 3 edges, n=15 -> 48 edges.
- over and busy are decoded from the next state and registered, so they are aligned with state entry and glitch-free.
- in may change any time after INIT without effect. go toggling while busy is ignored.
- out during computation shows the partial sum and is only meaningful when over=1.
- After DONE->IDLE, out keeps the last result until the next INIT clears it.
- Restart requires go to be low for at least one cycle in DONE, then high in IDLE.

Optional Feature:
- Macro SQR_STEP_MERGE_EN.
- Defined:
  - STEP state is removed; ACC performs acc<=acc+k, cnt<=cnt+1, k<=k+2 in one cycle and goes -> CHECK.
  - Latency becomes 2n+3 edges (n=15 -> 33); FSM has 5 states.
- Undefined: 6-state FSM and 3n+3 latency exactly as above.
- Result values and handshake are identical in both builds.

Test Plan:
- Reset then go=1 with in=4'd8 -> over rises 27 edges after go is sampled; out=8'd64; busy=0 in DONE.
- in=4'd0, go=1 -> over after 3 edges, out=8'd0; in=4'd15 -> over after 48 edges, out=8'd225 (33 edges with SQR_STEP_MERGE_EN).
- Hold go=1 through DONE with in=4'd3 -> out=9 and the FSM stays in DONE. Drop go for 1 cycle, then raise it with in=4'd5 -> a second run gives out=25.
- Start in=4'd12, change in to 4'd2 and pulse go during busy -> result unaffected, out=8'd144.
- Assert reset=0 asynchronously mid-run for n=10 (between clock edges) -> over=0, busy=0, out=0 immediately. After release, go with in=4'd7 -> out=8'd49.
- Sweep n=0..15 with a scoreboard comparing against n*n. Loopback: feed out into the sqrt engine and check the recovered root equals n.
